// File: rtl/resp_misr_capture.sv
// Response compactor: folds a wide response bus into a 32-bit MISR over a
// programmed number of samples and flags a match against a golden signature.
module resp_misr_capture #(
  parameter int          WIDTH = 330,
  parameter int          SIG_W = 32,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter logic [31:0] SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      cycles,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] resp_flat,
  input  logic [SIG_W-1:0] expect_sig,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [31:0]      sample_count,
  output logic             match
);

  localparam int NCH = (WIDTH + SIG_W - 1) / SIG_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [SIG_W-1:0]   sig_reg, sig_next;
  logic [31:0]        count_reg, count_next;
  logic [31:0]        target_reg, target_next;
  logic               busy_reg, done_reg, match_reg;
  logic               match_next;

  logic [NCH*SIG_W-1:0] padded;
  logic [SIG_W-1:0]     chunk [NCH];
  logic [SIG_W-1:0]     fold;
  logic [SIG_W-1:0]     misr_step;
  logic [31:0]          count_inc;

  // Top chunk is zero-extended by padding the bus out to a whole number of chunks.
  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = resp_flat;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chunk
      assign chunk[gi] = padded[gi*SIG_W +: SIG_W];
    end
  endgenerate

  always_comb begin
    fold = '0;
    for (int i = 0; i < NCH; i++) begin
      fold = fold ^ chunk[i];
    end
  end

  assign misr_step = {sig_reg[SIG_W-2:0], 1'b0}
                   ^ (sig_reg[SIG_W-1] ? POLY[SIG_W-1:0] : '0)
                   ^ fold;
  assign count_inc = count_reg + 32'd1;

  // Priority: abort, then start, then sample_en.
  always_comb begin
    state_next  = state_reg;
    sig_next    = sig_reg;
    count_next  = count_reg;
    target_next = target_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            sig_next    = SEED[SIG_W-1:0];
            count_next  = '0;
            target_next = cycles;
            state_next  = (cycles == 32'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (sample_en) begin
            sig_next   = misr_step;
            count_next = count_inc;
            if (count_inc == target_reg) begin
              state_next = DONE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Compare against next-state values so match is valid on the same edge as done.
  assign match_next = (state_next == DONE) && (sig_next == expect_sig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sig_reg    <= '0;
      count_reg  <= '0;
      target_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      match_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sig_reg    <= sig_next;
      count_reg  <= count_next;
      target_reg <= target_next;
      busy_reg   <= (state_next == RUN);
      done_reg   <= (state_next == DONE);
      match_reg  <= match_next;
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign signature    = sig_reg;
  assign sample_count = count_reg;
  assign match        = match_reg;

endmodule

// File: doc/resp_misr_capture.md
# resp_misr_capture

On-chip response compactor for the fuzz harness. It samples the DUT's wide flat output bus (`out_flat`) once per enabled cycle and folds it into a 32-bit multiple-input signature register (MISR). At the end of a programmed sample window it reports the final signature and a match flag against an expected value. It is the receiving end of the LCG stimulus path: stimulus drives `in_flat`, and this block reads `out_flat` so that long runs can be compared across simulators by signature alone.

## Interface
- `WIDTH`, 330: width of the response bus.
- `SIG_W`, 32: signature width. It is fixed at 32; other values are unsupported.
- `POLY`, 32'h04C11DB7: MISR feedback polynomial.
- `SEED`, 32'hFFFFFFFF: signature value loaded on `start`.

Clocking and reset (already decided): one clock; reset is asynchronous and active-low.

- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: begin a capture window. Honoured in IDLE and DONE only.
- `abort`, input, 1: end the window early and return to IDLE.
- `cycles`, input, 32: number of samples in the window. Latched on an accepted `start`.
- `sample_en`, input, 1: the current `resp_flat` counts as a sample.
- `resp_flat`, input, WIDTH: response bus to compact.
- `expect_sig`, input, 32: golden signature. Compared combinationally against `signature`, then registered.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: high in DONE (a level, not a pulse).
- `signature`, output, 32: current MISR value.
- `sample_count`, output, 32: samples taken in the current window.
- `match`, output, 1: `done && signature == expect_sig`, registered.

## Operation
- **Fold step**
  - Split `resp_flat` into ceil(WIDTH/32) 32-bit chunks starting at bit 0.
  - The top chunk is zero-extended.
  - `fold` = XOR of all chunks. With WIDTH=330 that is 11 chunks, and chunk 10 is bits 329:320.
- **MISR step**
  - `t = {sig[30:0],1'b0}`.
  - If `sig[31]` is 1, `t ^= POLY`.
  - `sig_next = t ^ fold`. All arithmetic is modulo 2^32.
- **States:** IDLE, RUN, DONE. Encoding is free.
- **IDLE**
  - On `start`: `signature <= SEED`, `sample_count <= 0`, latch `cycles` into `target`.
  - If `cycles == 0`, go to DONE. Otherwise go to RUN.
- **RUN**
  - On a `sample_en` cycle: update `signature` and increment `sample_count`.
  - If the incremented count equals `target`, go to DONE on the same edge.
  - A cycle with `sample_en` low leaves all state unchanged.
  - `start` is ignored in RUN.
- **DONE**
  - `signature` and `sample_count` hold.
  - `start` re-arms exactly as it does from IDLE.
  - `sample_en` is ignored.
- **abort**
  - Valid in any state; takes priority over `start` and `sample_en`.
  - Next state is IDLE. `signature` and `sample_count` keep their last values, so a partial result stays readable.
- **Priority within one cycle:** reset, then `abort`, then `start`, then `sample_en`.

## Timing
- **Reset values:**
  - `busy`=0, `done`=0, `match`=0.
  - `signature`=32'h0, `sample_count`=0.
  - State = IDLE, `target`=0.
- **Reset mid-window** returns everything to the reset values immediately (asynchronous). There is no resume.
- **All outputs are registered.** No combinational input-to-output paths.
- **`start` accepted at edge T:**
  - `busy` is high after T.
  - The first sample can be taken at edge T+1; `resp_flat` and `sample_en` are sampled at T+1.
- **Final (Nth) sample at edge E:** after E, `done`=1, `busy`=0, `signature` is final, and `match` is valid.
- **`cycles`=0 with `start` at T:** after T, `done`=1 and `signature`=SEED.
- **`match`** is registered every cycle, so it tracks changes on `expect_sig` one cycle later.
- **`sample_count` wrap** cannot occur, because `target` is at most 2^32−1 and the count stops at `target`.

## Test plan
1. **Single zero sample.** `SEED`=FFFFFFFF, `resp_flat`=0, `cycles`=1, `sample_en` held high. Required: `done`=1 one edge after the first RUN edge, `signature`=FB3EE249, `sample_count`=1.
2. **Constant input, two samples.** `SEED`=0, `resp_flat`=1, `cycles`=2. Required: `signature` reads 00000001 after the first sample and 00000003 after the second; `done`=1 and `busy`=0. With `expect_sig`=3, `match`=1.
3. **Fold cancellation.** `SEED`=0, `resp_flat` bits 0 and 320 set, `cycles`=4. Required: `signature`=00000000 and `match`=1 against `expect_sig`=0.
4. **Gapped sampling.** `cycles`=3, `sample_en` pattern 1,0,0,1,0,1. Required: `done` asserts after the 6th RUN edge; the signature equals the one from 3 back-to-back samples of the same data.
5. **Edge controls.**
   - `cycles`=0: `done`=1 with `signature`=SEED one edge after `start`.
   - `start` during RUN: ignored, and `sample_count` continues.
   - `start` in DONE: restarts from SEED.
6. **Abort and reset.**
   - `abort` after 2 of 5 samples: IDLE, `busy`=0, `done`=0, `sample_count`=2, `signature` held.
   - `rst_n` pulsed low mid-RUN: all outputs go to zero without waiting for `clk`.
